fetch_stage: RTL

- Instruction-fetch stage sitting directly downstream of the PC register.
- Consumes the current PC, runs the I-cache request handshake, and drives the PC register's write enable.
- Owns the IF/ID pipeline register that feeds decode.
- Turns I-cache misses into bubbles, holds fetched instructions across hazard stalls, and discards in-flight fetches on a redirect flush.

---
 rtl/fetch_stage_if.sv | 22 ++
 rtl/fetch_stage.sv | 90 +++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: PC, hazard/flush, I-cache handshake and IF/ID bundle for the fetch stage.
interface fetch_stage_if;
  logic [31:0] pc;
  logic        hazard_stall;
  logic        flush;
  logic        icache_stall;
  logic [31:0] icache_rdata;
  logic        icache_ren;
  logic [29:0] icache_addr;
  logic        pc_write;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_inst;
  logic        if_id_valid;
  modport master (
    input  pc, hazard_stall, flush, icache_stall, icache_rdata,
    output icache_ren, icache_addr, pc_write, if_id_pc, if_id_inst, if_id_valid
  );
  modport slave (
    output pc, hazard_stall, flush, icache_stall, icache_rdata,
    input  icache_ren, icache_addr, pc_write, if_id_pc, if_id_inst, if_id_valid
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: I-cache request handshake, PC write enable and IF/ID register with miss
// bubbles, hazard hold buffer and redirect drain of in-flight misses.
module fetch_stage #(
  parameter bit          SWAP_INST = 1'b1,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input logic           clk_i,
  input logic           rst_i,
  fetch_stage_if.master bus
);
  typedef enum logic [1:0] {S_FETCH, S_DRAIN, S_HOLD} state_t;
  typedef enum logic [1:0] {L_HOLD, L_BUB, L_NEW, L_BUF} load_t;
  state_t      state_q, state_d;
  load_t       sel;
  logic        busy_q, pw, buf_ld, complete;
  logic [29:0] req_addr_q;
  logic [31:0] buf_pc_q, buf_inst_q, inst, rd;
  assign rd = bus.icache_rdata;
  assign inst = SWAP_INST ? {rd[7:0], rd[15:8], rd[23:16], rd[31:24]} : rd;
  assign bus.icache_ren = rst_i && state_q != S_HOLD;
  assign bus.icache_addr = busy_q ? req_addr_q : bus.pc[31:2];
  assign bus.pc_write = rst_i && pw;
  assign complete = bus.icache_ren && !bus.icache_stall;
  always_comb begin
    state_d = state_q;
    pw = 1'b0;
    buf_ld = 1'b0;
    sel = bus.hazard_stall ? L_HOLD : L_BUB;
    case (state_q)
      S_FETCH:
        if (bus.flush) begin
          pw = 1'b1;
          sel = L_BUB;
          state_d = bus.icache_stall ? S_DRAIN : S_FETCH;
        end else if (complete) begin
          pw = !bus.hazard_stall;
          buf_ld = bus.hazard_stall;
          sel = bus.hazard_stall ? L_HOLD : L_NEW;
          state_d = bus.hazard_stall ? S_HOLD : S_FETCH;
        end
      S_DRAIN: begin
        if (bus.flush) begin
          pw = 1'b1;
          sel = L_BUB;
        end
        state_d = bus.icache_stall ? S_DRAIN : S_FETCH;
      end
      S_HOLD:
        if (bus.flush) begin
          pw = 1'b1;
          sel = L_BUB;
          state_d = S_FETCH;
        end else if (!bus.hazard_stall) begin
          pw = 1'b1;
          sel = L_BUF;
          state_d = S_FETCH;
        end
      default: state_d = S_FETCH;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      busy_q <= 1'b0;
      req_addr_q <= '0;
      buf_pc_q <= '0;
      buf_inst_q <= '0;
      bus.if_id_pc <= '0;
      bus.if_id_inst <= NOP_INST;
      bus.if_id_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!bus.icache_stall) busy_q <= 1'b0;
      else if (bus.icache_ren) begin
        busy_q <= 1'b1;
        req_addr_q <= bus.icache_addr;
      end
      if (buf_ld) begin
        buf_pc_q <= bus.pc;
        buf_inst_q <= inst;
      end
      case (sel)
        L_NEW: {bus.if_id_pc, bus.if_id_inst, bus.if_id_valid} <= {bus.pc, inst, 1'b1};
        L_BUF: {bus.if_id_pc, bus.if_id_inst, bus.if_id_valid} <= {buf_pc_q, buf_inst_q, 1'b1};
        L_BUB: {bus.if_id_pc, bus.if_id_inst, bus.if_id_valid} <= {32'd0, NOP_INST, 1'b0};
        default: ;
      endcase
    end
  end
endmodule
